// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains a show-ahead-less FIFO into an 8N1-style serial line. One FIFO
// entry is popped per frame, and each frame is sent as a start bit, WIDTH
// data bits LSB first, and a stop bit. Each bit lasts PRESCALE clock cycles.
//
// Parameters
//   PRESCALE  clock cycles per serial bit (2..65535)
//   WIDTH     data bits per frame, matches the feeding FIFO width
//
// Ports
//   i_clock    single clock, rising-edge active
//   i_reset_n  synchronous active-low reset
//   i_empty    FIFO empty flag
//   o_read     FIFO pop strobe, combinational, only ever high in IDLE
//   i_rdata    FIFO read data, valid the cycle after o_read
//   o_tx       registered serial output, idle high
//   o_busy     high whenever a frame is being loaded or sent

module fifo_uart_tx #(
  parameter int PRESCALE = 16,
  parameter int WIDTH    = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_empty,
  output logic             o_read,
  input  logic [WIDTH-1:0] i_rdata,
  output logic             o_tx,
  output logic             o_busy
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] COUNT_LAST = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic [BW-1:0]    bit_idx;
  logic             bit_end;

  // The pop is gated by reset and empty so the FIFO is never read while
  // empty and never popped while the block is held in reset.
  assign o_read  = (state == IDLE) && i_reset_n && !i_empty;
  assign o_busy  = (state != IDLE);
  assign bit_end = (count == COUNT_LAST);

  // o_tx is loaded with the level of the state being entered, so the line
  // changes exactly on state and bit boundaries without any decode glitch.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      o_tx    <= 1'b1;
      shreg   <= '0;
      count   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (o_read) begin
            state <= LOAD;
          end
        end

        // FIFO data arrives one cycle after the pop, so it is captured here.
        LOAD: begin
          shreg <= i_rdata;
          count <= '0;
          o_tx  <= 1'b0;
          state <= START;
        end

        START: begin
          if (bit_end) begin
            count   <= '0;
            bit_idx <= '0;
            o_tx    <= shreg[0];
            state   <= DATA;
          end else begin
            count <= count + 1'b1;
          end
        end

        // shreg[1] is the bit that becomes bit 0 after this shift.
        DATA: begin
          if (bit_end) begin
            count   <= '0;
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              o_tx <= shreg[1];
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        STOP: begin
          o_tx <= 1'b1;
          if (bit_end) begin
            count <= '0;
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end

        default: begin
          o_tx  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 16, clock cycles per serial bit, legal range 2..65535.
REQ-002 The block SHALL have parameter WIDTH, default 8, data bits per frame; it SHALL equal the WIDTH of the FIFO that feeds the block.
REQ-003 The block SHALL run on one clock, with a reset that is synchronous and active-low.
REQ-004 The block SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port i_empty, input, 1 bit: FIFO empty flag.
REQ-007 The block SHALL have port o_read, output, 1 bit: FIFO pop strobe.
REQ-008 The block SHALL have port i_rdata, input, WIDTH bits: FIFO read data, valid on the cycle after the o_read cycle.
REQ-009 The block SHALL have port o_tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The block SHALL implement the states IDLE, LOAD, START, DATA and STOP.
REQ-012 In IDLE, o_read SHALL be combinational and equal to (i_reset_n and not i_empty); o_read SHALL be 0 in every other state.
REQ-013 When o_read is 1, the next state SHALL be LOAD; otherwise the state SHALL stay IDLE.
REQ-014 The block SHALL never assert o_read while i_empty=1, because the FIFO does not guard against reads when empty.
REQ-015 o_read SHALL be high for exactly one cycle per frame.
REQ-016 LOAD SHALL last exactly one cycle: it captures i_rdata into the shift register, clears the prescale counter, and moves to START.
REQ-017 START SHALL drive o_tx=0 for exactly PRESCALE cycles, then move to DATA with the bit index at 0.
REQ-018 DATA SHALL drive o_tx equal to shift-register bit 0 (LSB first) for PRESCALE cycles per bit.
REQ-019 At the end of each bit in DATA, the shift register SHALL shift right by one and the bit index SHALL increment; after WIDTH bits the state SHALL move to STOP.
REQ-020 STOP SHALL drive o_tx=1 for exactly PRESCALE cycles, then return to IDLE.
REQ-021 o_tx SHALL be 1 in the IDLE and LOAD states.
REQ-022 o_tx SHALL be registered (glitch-free); its transitions SHALL coincide with state or bit boundaries.
REQ-023 The prescale counter SHALL be $clog2(PRESCALE) bits wide, count 0..PRESCALE-1, and wrap to 0 at each bit boundary.
REQ-024 The bit index SHALL be $clog2(WIDTH+1) bits wide.
REQ-025 Frame length SHALL be (WIDTH+2)*PRESCALE cycles of o_tx activity.
REQ-026 For back-to-back frames, the minimum pop-to-pop spacing SHALL be (WIDTH+2)*PRESCALE+2 cycles; the extra IDLE and LOAD cycles appear as extended stop (o_tx=1).
REQ-027 Changes on i_empty outside IDLE SHALL be ignored; no pop SHALL occur mid-frame.
REQ-028 i_rdata SHALL be sampled only in LOAD; i_rdata changes at other times SHALL have no effect.
REQ-029 o_busy SHALL rise on the cycle after the o_read cycle (LOAD) and fall on the cycle IDLE is re-entered.

Reset
REQ-030 While i_reset_n=0 at a rising edge, the next state SHALL be IDLE, o_tx SHALL be 1, and the shift register, prescale counter and bit index SHALL be 0.
REQ-031 While i_reset_n=0, o_read SHALL be 0 regardless of i_empty.
REQ-032 Reset asserted mid-frame (any state) SHALL abort the frame: o_tx SHALL be 1 from the first cycle after the reset edge, and the aborted byte SHALL NOT be retransmitted.
REQ-033 After i_reset_n returns to 1, the block SHALL resume in IDLE and pop the next byte if i_empty=0.
REQ-034 Outputs after reset SHALL be: o_tx=1, o_busy=0, o_read=0.

Verification
REQ-035 PRESCALE=4, WIDTH=8, FIFO holds 0xA5 -> one o_read pulse; o_tx sequence in 4-cycle slots = 0,1,0,1,0,0,1,0,1,1; o_busy high for 41 cycles (LOAD + 40 serial cycles).
REQ-036 i_empty=1 held for 100 cycles after reset -> o_read=0, o_tx=1, o_busy=0 throughout.
REQ-037 FIFO holds 0x00 then 0xFF -> two frames, pops exactly 42 cycles apart; o_tx high for exactly 2 extra cycles between the stop bit and the second start bit.
REQ-038 i_reset_n pulled low for 1 cycle during data bit 3 of 0x55 -> o_tx=1 from the next cycle; o_busy=0; the next pop fetches the following FIFO entry, not 0x55.
REQ-039 Bench assertion over random traffic (PRESCALE=2, 1000 bytes): o_read never high while i_empty=1; received bytes equal sent bytes in order; FIFO pointers never overrun.
REQ-040 PRESCALE=2, WIDTH=8, i_rdata changed in every non-LOAD cycle -> the transmitted byte equals the value present in LOAD only.
